load_unit_seq: RTL and testbench

Load-path sequencer between the core's memory stage and the data-memory port. It accepts one load request at a time, issues one or two word-aligned reads on the memory bus, and merges the returned words. It then extracts and sign- or zero-extends the byte, halfword or word named by the request and returns the result through a registered response handshake. Loads that cross a word boundary are split into two reads, or are faulted, depending on a parameter.

---
 rtl/load_unit_seq.sv | 204 ++++++++++++++++++++
 tb/tb_load_unit_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit_seq.sv
// Load-path sequencer: accepts one load, issues one or two word-aligned reads,
// merges the returned words and returns the extended result over a registered
// response handshake.
module load_unit_seq #(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int LOAD_OP_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [LOAD_OP_WIDTH-1:0] req_op,
  input  logic                     abort,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  input  logic [31:0]              mem_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_fault
);

  // Load op encodings (funct3 values of the RISC-V load instructions)
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = LOAD_OP_WIDTH'(0);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = LOAD_OP_WIDTH'(1);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = LOAD_OP_WIDTH'(2);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = LOAD_OP_WIDTH'(4);
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = LOAD_OP_WIDTH'(5);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [LOAD_OP_WIDTH-1:0] op_q, op_d;
  logic [1:0]               off_q, off_d;
  logic                     split_q, split_d;
  logic [31:0]              lo_q, lo_d;
  logic                     mem_valid_d;
  logic [31:0]              mem_addr_d;
  logic                     rsp_valid_d;
  logic [31:0]              rsp_data_d;
  logic                     rsp_fault_d;

  // Request classification
  logic       req_is_half, req_is_word, req_legal, req_misal, req_split, req_bad;
  logic [1:0] req_off;

  // Shift the merged pair by the byte offset, then extend per op
  function automatic logic [31:0] extract(input logic [63:0] pair,
                                          input logic [1:0] off,
                                          input logic [LOAD_OP_WIDTH-1:0] op);
    logic [63:0] sh;
    logic [31:0] w;
    sh = pair >> {off, 3'b000};
    w  = sh[31:0];
    case (op)
      LOAD_OP_LB:  extract = {{24{w[7]}}, w[7:0]};
      LOAD_OP_LBU: extract = {24'h0, w[7:0]};
      LOAD_OP_LH:  extract = {{16{w[15]}}, w[15:0]};
      LOAD_OP_LHU: extract = {16'h0, w[15:0]};
      LOAD_OP_LW:  extract = w;
      default:     extract = '0;
    endcase
  endfunction

  // Decode the incoming request
  always_comb begin
    req_off     = req_addr[1:0];
    req_is_half = (req_op == LOAD_OP_LH) || (req_op == LOAD_OP_LHU);
    req_is_word = (req_op == LOAD_OP_LW);
    req_legal   = req_is_half || req_is_word ||
                  (req_op == LOAD_OP_LB) || (req_op == LOAD_OP_LBU);
    req_misal   = (req_is_half && req_off[0]) || (req_is_word && (req_off != 2'd0));
    req_split   = (ALLOW_MISALIGNED != 0) &&
                  ((req_is_half && (req_off == 2'd3)) || (req_is_word && (req_off != 2'd0)));
    req_bad     = !req_legal || (req_misal && (ALLOW_MISALIGNED == 0));
  end

  assign req_ready = resetn && (state_q == IDLE) && !abort;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    split_d     = split_q;
    lo_d        = lo_q;
    mem_valid_d = mem_valid;
    mem_addr_d  = mem_addr;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_fault_d = rsp_fault;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          off_d   = req_off;
          split_d = req_split;
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d     = RD0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
          end
        end
      end
      RD0: begin
        if (mem_ready) begin
          lo_d = mem_rdata;
          if (abort) begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
          end else if (split_q) begin
            state_d    = RD1;
            mem_addr_d = mem_addr + 32'd4;
          end else begin
            state_d     = RESP;
            mem_valid_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_data_d  = extract({32'h0, mem_rdata}, off_q, op_q);
          end
        end else if (abort) begin
          state_d = DRAIN;
        end
      end
      RD1: begin
        // The high word is merged straight off the bus rather than parked in
        // a register, so the response is ready on the same edge.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (abort) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_data_d  = extract({mem_rdata, lo_q}, off_q, op_q);
          end
        end else if (abort) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (abort || rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_data_d  = '0;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      op_q      <= '0;
      off_q     <= '0;
      split_q   <= 1'b0;
      lo_q      <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      off_q     <= off_d;
      split_q   <= split_d;
      lo_q      <= lo_d;
      mem_valid <= mem_valid_d;
      mem_addr  <= mem_addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_fault <= rsp_fault_d;
    end
  end

endmodule

// File: tb/tb_load_unit_seq.sv
// Directed self-checking bench for load_unit_seq: one instance with
// misaligned support, one instance in fault mode.
module tb_load_unit_seq;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, abort;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_data;

  logic        f_req_valid, f_req_ready, f_abort;
  logic [31:0] f_req_addr;
  logic [2:0]  f_req_op;
  logic        f_mem_valid, f_mem_ready;
  logic [31:0] f_mem_addr, f_mem_rdata;
  logic        f_rsp_valid, f_rsp_ready, f_rsp_fault;
  logic [31:0] f_rsp_data;

  int checks   = 0;
  int failures = 0;

  load_unit_seq #(.ALLOW_MISALIGNED(1), .LOAD_OP_WIDTH(3)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
    .abort(abort),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
  );

  load_unit_seq #(.ALLOW_MISALIGNED(0), .LOAD_OP_WIDTH(3)) dut_f (
    .clk(clk), .resetn(resetn),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_addr(f_req_addr), .req_op(f_req_op),
    .abort(f_abort),
    .mem_valid(f_mem_valid), .mem_ready(f_mem_ready), .mem_addr(f_mem_addr), .mem_rdata(f_mem_rdata),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_fault(f_rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-read load with zero wait states; response consumed immediately
  task automatic simple_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_maddr,
                             input logic [31:0] exp_data);
    mem_ready = 1'b1; mem_rdata = rdata; rsp_ready = 1'b1;
    req_op = op; req_addr = addr; req_valid = 1'b1;
    #1 chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, exp_maddr);
    chk({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_data"}, rsp_data, exp_data);
    chk({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
    chk({tag, "_mem_idle"}, 32'(mem_valid), 32'd0);
    step();
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = OP_LB; abort = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    f_req_valid = 1'b0; f_req_addr = '0; f_req_op = OP_LB; f_abort = 1'b0;
    f_mem_ready = 1'b0; f_mem_rdata = '0; f_rsp_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    resetn = 1'b1;
    step();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Aligned word and in-word sub-word loads
    simple_load("lw_al", OP_LW, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF);
    simple_load("lb", OP_LB, 32'h0000_2003, 32'h80FF_7F01, 32'h0000_2000, 32'hFFFF_FF80);
    simple_load("lbu", OP_LBU, 32'h0000_2003, 32'h80FF_7F01, 32'h0000_2000, 32'h0000_0080);
    simple_load("lh", OP_LH, 32'h0000_2001, 32'h80FF_7F01, 32'h0000_2000, 32'hFFFF_FF7F);
    simple_load("lhu2", OP_LHU, 32'h0000_2002, 32'h80FF_7F01, 32'h0000_2000, 32'h0000_80FF);

    // Split LHU at offset 3, zero wait states
    mem_ready = 1'b1; mem_rdata = 32'hAB00_0000; rsp_ready = 1'b1;
    req_op = OP_LHU; req_addr = 32'h0000_3003; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("slhu_addr0", mem_addr, 32'h0000_3000);
    step();
    chk("slhu_valid1", 32'(mem_valid), 32'd1);
    chk("slhu_addr1", mem_addr, 32'h0000_3004);
    chk("slhu_rsp_early", 32'(rsp_valid), 32'd0);
    mem_rdata = 32'h0000_00CD;
    step();
    chk("slhu_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("slhu_rsp_data", rsp_data, 32'h0000_CDAB);
    chk("slhu_mem_idle", 32'(mem_valid), 32'd0);
    mem_ready = 1'b0;
    step();

    // Split LW wrapping past the top of memory, two wait states per read
    req_op = OP_LW; req_addr = 32'hFFFF_FFFE; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_rd0_valid", 32'(mem_valid), 32'd1);
      chk("wrap_rd0_addr", mem_addr, 32'hFFFF_FFFC);
      if (i == 2) begin
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
      end
      step();
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_rd1_valid", 32'(mem_valid), 32'd1);
      chk("wrap_rd1_addr", mem_addr, 32'h0000_0000);
      chk("wrap_rsp_early", 32'(rsp_valid), 32'd0);
      if (i == 2) begin
        mem_ready = 1'b1; mem_rdata = 32'h5566_7788;
      end
      step();
    end
    mem_ready = 1'b0;
    chk("wrap_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wrap_rsp_data", rsp_data, 32'h7788_1122);
    step();

    // Illegal op faults without touching memory
    req_op = 3'd3; req_addr = 32'h0000_0100; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_rsp_fault", 32'(rsp_fault), 32'd1);
    chk("ill_mem_valid", 32'(mem_valid), 32'd0);
    step();
    chk("ill_rsp_done", 32'(rsp_valid), 32'd0);

    // Fault mode: misaligned LW, response held while not accepted
    f_req_op = OP_LW; f_req_addr = 32'h0000_4002; f_req_valid = 1'b1; f_rsp_ready = 1'b0;
    step();
    f_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flt_rsp_valid", 32'(f_rsp_valid), 32'd1);
      chk("flt_rsp_fault", 32'(f_rsp_fault), 32'd1);
      chk("flt_rsp_data", f_rsp_data, 32'd0);
      chk("flt_mem_valid", 32'(f_mem_valid), 32'd0);
      step();
    end
    f_rsp_ready = 1'b1;
    step();
    chk("flt_rsp_done", 32'(f_rsp_valid), 32'd0);
    chk("flt_req_ready", 32'(f_req_ready), 32'd1);

    // Abort blocks acceptance in IDLE
    abort = 1'b1; req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_5000;
    #1 chk("abort_idle_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_no_mem", 32'(mem_valid), 32'd0);

    // Abort during first read of a split LW with the bus stalled
    req_op = OP_LW; req_addr = 32'h0000_5001; req_valid = 1'b1; mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("drain_mem_valid", 32'(mem_valid), 32'd1);
    chk("drain_mem_addr", mem_addr, 32'h0000_5000);
    chk("drain_req_ready", 32'(req_ready), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_no_rd1", 32'(mem_valid), 32'd0);
      chk("drain_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    simple_load("after_abort", OP_LW, 32'h0000_6000, 32'h0123_4567, 32'h0000_6000, 32'h0123_4567);

    // Abort in RESP drops the response
    mem_ready = 1'b1; mem_rdata = 32'h0000_0042; rsp_ready = 1'b0;
    req_op = OP_LBU; req_addr = 32'h0000_6100; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_ready = 1'b0;
    chk("rabort_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rabort_rsp_data", rsp_data, 32'h0000_0042);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("rabort_dropped", 32'(rsp_valid), 32'd0);

    // Reset in the middle of the second read of a split load
    mem_ready = 1'b1; mem_rdata = 32'hFF00_0000; rsp_ready = 1'b1;
    req_op = OP_LHU; req_addr = 32'h0000_7003; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_rst_rd1_addr", mem_addr, 32'h0000_7004);
    mem_ready = 1'b0; resetn = 1'b0;
    #1 chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    step();
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_rsp_fault", 32'(rsp_fault), 32'd0);
    resetn = 1'b1;
    step();
    chk("mid_rst_ready_back", 32'(req_ready), 32'd1);
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
